pc_target_unit: RTL

//  Parametrised next-PC / jump-target unit for the accumulator datapath. Supersedes
//  the fixed 2-bit-PC + 14-bit-shifted-IR concatenator. Owns the PC register and

---
 rtl/pc_target_pkg.sv | 15 +
 rtl/pc_target_calc.sv | 48 ++++
 rtl/pc_target_unit.sv | 85 ++++++++
 3 files changed

// File: rtl/pc_target_pkg.sv
// pc_target_pkg: shared encodings for the next-PC / jump-target unit.
//   modeT  : target select driven on pc_target_unit.Mode
//   stateT : redirect FSM (RUN = free running, HOLD = redirect parked behind a stall)
package pc_target_pkg;
  typedef enum logic [1:0] {
    SEQ    = 2'b00,
    JUMP   = 2'b01,
    BRANCH = 2'b10,
    REG    = 2'b11
  } modeT;
  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } stateT;
endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc: combinational target formation from the current PC.
//   pc        in   current program counter
//   mode      in   target select (modeT encoding)
//   imm       in   instruction immediate
//   regTarget in   register jump target
//   condTrue  in   branch condition
//   target    out  selected next PC (SEQ when no redirect is requested)
//   seqTgt    out  pc + INC, also used as the link/return address
//   req       out  a non-sequential target is requested
//   misalign  out  REG request whose target has nonzero alignment bits
module pc_target_calc
  import pc_target_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 13,
  parameter int SHIFT  = 1,
  parameter int INC    = 2
) (
  input  logic [DATA_W-1:0] pc,
  input  logic [1:0]        mode,
  input  logic [IMM_W-1:0]  imm,
  input  logic [DATA_W-1:0] regTarget,
  input  logic              condTrue,
  output logic [DATA_W-1:0] target,
  output logic [DATA_W-1:0] seqTgt,
  output logic              req,
  output logic              misalign
);
  // Bits below the alignment boundary, and bits covered by the shifted immediate;
  // expressed as masks so a zero-width PC high field needs no special case.
  localparam logic [DATA_W-1:0] ALIGN_MASK = DATA_W'((64'd1 << SHIFT) - 64'd1);
  localparam logic [DATA_W-1:0] LO_MASK    = DATA_W'((64'd1 << (IMM_W + SHIFT)) - 64'd1);
  logic [DATA_W-1:0] immSext, jumpTgt, branchTgt, regTgt;
  logic              isJump, isBranch, isReg;
  always_comb begin
    isJump    = mode == JUMP;
    isBranch  = mode == BRANCH;
    isReg     = mode == REG;
    immSext   = DATA_W'($signed(imm));
    seqTgt    = pc + DATA_W'(INC);
    jumpTgt   = (pc & ~LO_MASK) | (DATA_W'(imm) << SHIFT);
    branchTgt = condTrue ? pc + (immSext << SHIFT) : seqTgt;
    regTgt    = regTarget & ~ALIGN_MASK;
    req       = isJump | isReg | (isBranch & condTrue);
    misalign  = isReg & |(regTarget & ALIGN_MASK);
    target    = isJump ? jumpTgt : isBranch ? branchTgt : isReg ? regTgt : seqTgt;
  end
endmodule

// File: rtl/pc_target_unit.sv
// pc_target_unit: owns the PC, parks one redirect across fetch stalls, captures link address.
//   CLK         in   clock, all state on rising edge
//   Reset_n     in   synchronous reset, active-low
//   Mode        in   target select (SEQ/JUMP/BRANCH/REG)
//   Imm         in   instruction immediate
//   RegTarget   in   register jump target
//   CondTrue    in   branch condition (BRANCH only)
//   Link        in   capture return address with this redirect
//   Stall       in   fetch not ready, PC holds
//   PC          out  program counter
//   LinkAddr    out  captured return address
//   Redirect    out  PC just loaded a non-sequential target
//   Pending     out  redirect parked awaiting stall release
//   MisalignErr out  sticky REG misalignment flag
module pc_target_unit
  import pc_target_pkg::*;
#(
  parameter int                 DATA_W   = 16,
  parameter int                 IMM_W    = 13,
  parameter int                 SHIFT    = 1,
  parameter int                 INC      = 2,
  parameter logic [DATA_W-1:0]  RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic [1:0]        Mode,
  input  logic [IMM_W-1:0]  Imm,
  input  logic [DATA_W-1:0] RegTarget,
  input  logic              CondTrue,
  input  logic              Link,
  input  logic              Stall,
  output logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] LinkAddr,
  output logic              Redirect,
  output logic              Pending,
  output logic              MisalignErr
);
  stateT             state, nextState;
  logic [DATA_W-1:0] pendTgt, target, seqTgt, pcNext, pendNext;
  logic              req, misalign, redirectNext;
  pc_target_calc #(
    .DATA_W(DATA_W),
    .IMM_W (IMM_W),
    .SHIFT (SHIFT),
    .INC   (INC)
  ) calc (
    .pc       (PC),
    .mode     (Mode),
    .imm      (Imm),
    .regTarget(RegTarget),
    .condTrue (CondTrue),
    .target   (target),
    .seqTgt   (seqTgt),
    .req      (req),
    .misalign (misalign)
  );
  // On release from HOLD a fresh request outranks the parked one; otherwise
  // the parked target is taken.
  always_comb begin
    nextState    = (state == RUN) ? ((Stall && req) ? HOLD : RUN) : (Stall ? HOLD : RUN);
    pcNext       = Stall ? PC : (state == HOLD && !req) ? pendTgt : target;
    pendNext     = (Stall && req) ? target : pendTgt;
    redirectNext = !Stall && (req || state == HOLD);
  end
  always_ff @(posedge CLK) begin
    if (!Reset_n) state <= RUN;
    else          state <= nextState;
  end
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      PC          <= RESET_PC;
      pendTgt     <= '0;
      LinkAddr    <= '0;
      Redirect    <= 1'b0;
      MisalignErr <= 1'b0;
    end else begin
      PC          <= pcNext;
      pendTgt     <= pendNext;
      LinkAddr    <= (Link && req) ? seqTgt : LinkAddr;
      Redirect    <= redirectNext;
      MisalignErr <= MisalignErr | misalign;
    end
  end
  assign Pending = state == HOLD;
endmodule
